// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: register tags and the pipeline tracker slot record.
package cpu_types_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    typedef logic [REG_W-1:0] reg_tag_t;

    typedef struct packed {
        logic     valid;
        reg_tag_t rs;
        reg_tag_t rt;
        reg_tag_t rd;
        logic     regWr;
        logic     memRd;
        logic     memWr;
    } slot_t;

    localparam int unsigned SLOT_W = $bits(slot_t);

    localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/tracker_slot.sv
// One pipeline bookkeeping slot: holds, loads the incoming entry, or loads a bubble.
module tracker_slot
    import cpu_types_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hold,
    input  logic              i_bubble,
    input  logic [SLOT_W-1:0] i_d,
    output logic [SLOT_W-1:0] o_q
);

    logic [SLOT_W-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= BUBBLE;
        end else if (!i_hold) begin
            r_q <= i_bubble ? BUBBLE : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dest_tracker.sv
// Tracks register tags and write/load flags through EX, MEM and WB for forwarding,
// inserts load-use bubbles and counts every bubble inserted in front of a real instruction.
module dest_tracker #(
    parameter int unsigned REG_W = cpu_types_pkg::REG_W,
    parameter int unsigned CNT_W = cpu_types_pkg::CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regWr,
    input  logic             id_memRd,
    input  logic             id_memWr,
    input  logic             mem_wait,
    input  logic             flush_ex,
    output logic [REG_W-1:0] ex_rs,
    output logic [REG_W-1:0] ex_rt,
    output logic             ex_memWr,
    output logic [REG_W-1:0] mem_rd,
    output logic             mem_regWr,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_regWr,
    output logic             loaduse_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    import cpu_types_pkg::*;

    slot_t            w_id;
    slot_t            w_ex;
    slot_t            w_mem;
    slot_t            w_wb;
    logic             w_stall;
    logic             w_bubble;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Writes to r0 are dropped at capture so no later stage ever forwards them.
    always_comb begin
        w_id       = BUBBLE;
        w_id.valid = id_valid;
        w_id.rs    = id_rs;
        w_id.rt    = id_rt;
        w_id.rd    = id_rd;
        w_id.regWr = id_regWr & (id_rd != '0);
        w_id.memRd = id_memRd;
        w_id.memWr = id_memWr;
    end

    assign w_stall  = w_ex.valid & w_ex.memRd & w_ex.regWr & id_valid &
                      ((w_ex.rd == id_rs) | (id_uses_rt & (w_ex.rd == id_rt)));
    assign w_bubble = flush_ex | w_stall;

    tracker_slot u_ex (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_hold   (mem_wait),
        .i_bubble (w_bubble),
        .i_d      (w_id),
        .o_q      (w_ex)
    );

    tracker_slot u_mem (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_hold   (mem_wait),
        .i_bubble (1'b0),
        .i_d      (w_ex),
        .o_q      (w_mem)
    );

    tracker_slot u_wb (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_hold   (mem_wait),
        .i_bubble (1'b0),
        .i_d      (w_mem),
        .o_q      (w_wb)
    );

    // flush and stall share one bubble, so the increment is taken once per edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bubble_cnt <= '0;
        end else if (!mem_wait && w_bubble && id_valid && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign ex_rs         = w_ex.rs;
    assign ex_rt         = w_ex.rt;
    assign ex_memWr      = w_ex.valid & w_ex.memWr;
    assign mem_rd        = w_mem.rd;
    assign mem_regWr     = w_mem.valid & w_mem.regWr;
    assign wb_rd         = w_wb.rd;
    assign wb_regWr      = w_wb.valid & w_wb.regWr;
    assign loaduse_stall = w_stall;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_dest_tracker.sv
// Scoreboard bench for dest_tracker: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_dest_tracker;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  id_rd;
    logic        id_regWr;
    logic        id_memRd;
    logic        id_memWr;
    logic        mem_wait;
    logic        flush_ex;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic        ex_memWr;
    logic [4:0]  mem_rd;
    logic        mem_regWr;
    logic [4:0]  wb_rd;
    logic        wb_regWr;
    logic        loaduse_stall;
    logic [15:0] bubble_cnt;

    dest_tracker #(.REG_W(5), .CNT_W(16)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .id_rd         (id_rd),
        .id_regWr      (id_regWr),
        .id_memRd      (id_memRd),
        .id_memWr      (id_memWr),
        .mem_wait      (mem_wait),
        .flush_ex      (flush_ex),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_memWr      (ex_memWr),
        .mem_rd        (mem_rd),
        .mem_regWr     (mem_regWr),
        .wb_rd         (wb_rd),
        .wb_regWr      (wb_regWr),
        .loaduse_stall (loaduse_stall),
        .bubble_cnt    (bubble_cnt)
    );

    always #5 CLK = ~CLK;

    typedef enum int {
        F_EX_RS, F_EX_RT, F_EX_MEMWR, F_MEM_RD, F_MEM_REGWR,
        F_WB_RD, F_WB_REGWR, F_STALL, F_CNT
    } fld_e;

    typedef struct {
        string       name;
        fld_e        f;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] peek(fld_e f);
        case (f)
            F_EX_RS:     return {27'd0, ex_rs};
            F_EX_RT:     return {27'd0, ex_rt};
            F_EX_MEMWR:  return {31'd0, ex_memWr};
            F_MEM_RD:    return {27'd0, mem_rd};
            F_MEM_REGWR: return {31'd0, mem_regWr};
            F_WB_RD:     return {27'd0, wb_rd};
            F_WB_REGWR:  return {31'd0, wb_regWr};
            F_STALL:     return {31'd0, loaduse_stall};
            default:     return {16'd0, bubble_cnt};
        endcase
    endfunction

    task automatic push_exp(input string n, input fld_e f, input int unsigned v);
        exp_t e;
        e.name = n;
        e.f    = f;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic push_zero(input string n);
        push_exp({n, "_ex_rs"},     F_EX_RS,     0);
        push_exp({n, "_ex_rt"},     F_EX_RT,     0);
        push_exp({n, "_ex_memWr"},  F_EX_MEMWR,  0);
        push_exp({n, "_mem_rd"},    F_MEM_RD,    0);
        push_exp({n, "_mem_regWr"}, F_MEM_REGWR, 0);
        push_exp({n, "_wb_rd"},     F_WB_RD,     0);
        push_exp({n, "_wb_regWr"},  F_WB_REGWR,  0);
        push_exp({n, "_stall"},     F_STALL,     0);
        push_exp({n, "_cnt"},       F_CNT,       0);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic ut, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic mw);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_uses_rt = ut;
        id_rd      = rd;
        id_regWr   = rw;
        id_memRd   = mr;
        id_memWr   = mw;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic randomize_inputs();
        set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        mem_wait = 1'($urandom);
        flush_ex = 1'($urandom);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares every queued expectation at the falling edge.
    initial begin
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(negedge CLK);
            while (sb.size() != 0) begin
                e   = sb.pop_front();
                got = peek(e.f);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.name, got, e.val);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        randomize_inputs();

        // Reset with random inputs
        tick(); randomize_inputs(); push_zero("rst_a");
        tick(); randomize_inputs(); push_zero("rst_b");
        tick();
        RST      = 1'b0;
        mem_wait = 1'b0;
        flush_ex = 1'b0;

        // Straight pipe: rd=3,5,7
        set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        tick();
        push_exp("pipe_ex_rs_i1", F_EX_RS, 1);
        push_exp("pipe_ex_rt_i1", F_EX_RT, 2);
        set_id(1, 5'd4, 5'd6, 1, 5'd5, 1, 0, 0);
        tick();
        push_exp("pipe_mem_rd_i1", F_MEM_RD, 3);
        set_id(1, 5'd9, 5'd10, 1, 5'd7, 1, 0, 0);
        tick();
        idle();
        push_exp("pipe_ex_rs",    F_EX_RS,     9);
        push_exp("pipe_ex_rt",    F_EX_RT,     10);
        push_exp("pipe_mem_rd",   F_MEM_RD,    5);
        push_exp("pipe_mem_wr",   F_MEM_REGWR, 1);
        push_exp("pipe_wb_rd",    F_WB_RD,     3);
        push_exp("pipe_wb_wr",    F_WB_REGWR,  1);
        push_exp("pipe_stall",    F_STALL,     0);
        tick(); tick(); tick();

        // Load-use on rs
        set_id(1, 5'd1, 5'd0, 0, 5'd8, 1, 1, 0);
        tick();
        set_id(1, 5'd8, 5'd2, 1, 5'd9, 1, 0, 0);
        push_exp("lu_stall_on",  F_STALL, 1);
        push_exp("lu_ex_load",   F_EX_RS, 1);
        push_exp("lu_cnt0",      F_CNT,   0);
        tick();
        push_exp("lu_stall_off", F_STALL,     0);
        push_exp("lu_ex_bubble", F_EX_RS,     0);
        push_exp("lu_mem_rd",    F_MEM_RD,    8);
        push_exp("lu_mem_wr",    F_MEM_REGWR, 1);
        push_exp("lu_cnt1",      F_CNT,       1);
        tick();
        idle();
        push_exp("lu_cons_rs",   F_EX_RS, 8);
        push_exp("lu_cons_rt",   F_EX_RT, 2);
        push_exp("lu_wb_rd",     F_WB_RD, 8);
        push_exp("lu_cnt_keep",  F_CNT,   1);
        tick(); tick();

        // Load-use on rt with uses_rt=1
        set_id(1, 5'd3, 5'd0, 0, 5'd8, 1, 1, 0);
        tick();
        set_id(1, 5'd4, 5'd8, 1, 5'd10, 1, 0, 0);
        push_exp("lurt_stall", F_STALL, 1);
        tick();
        push_exp("lurt_cnt2",  F_CNT,   2);
        push_exp("lurt_bub",   F_EX_RS, 0);
        tick();
        idle();
        push_exp("lurt_cons",  F_EX_RT, 8);
        tick();

        // rt match but rt not read: no stall
        set_id(1, 5'd3, 5'd0, 0, 5'd8, 1, 1, 0);
        tick();
        set_id(1, 5'd4, 5'd8, 0, 5'd10, 1, 0, 0);
        push_exp("nort_stall", F_STALL, 0);
        tick();
        idle();
        push_exp("nort_ex_rs", F_EX_RS,  4);
        push_exp("nort_mem",   F_MEM_RD, 8);
        push_exp("nort_cnt",   F_CNT,    2);
        tick(); tick();

        // rd=0 write is dropped
        set_id(1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);
        tick();
        idle();
        tick();
        push_exp("r0_mem_wr", F_MEM_REGWR, 0);
        push_exp("r0_mem_rd", F_MEM_RD,    0);
        tick();
        push_exp("r0_wb_wr",  F_WB_REGWR,  0);

        // flush with no real instruction is not counted; with one it is
        flush_ex = 1'b1;
        tick();
        push_exp("flush_idle_cnt", F_CNT, 2);
        set_id(1, 5'd5, 5'd6, 1, 5'd7, 1, 0, 0);
        tick();
        push_exp("flush_ex_rs", F_EX_RS, 0);
        push_exp("flush_cnt",   F_CNT,   3);
        flush_ex = 1'b0;
        idle();

        // Fill slots, then hold on mem_wait (flush also asserted, must lose)
        set_id(1, 5'd1, 5'd1, 1, 5'd11, 1, 0, 0);
        tick();
        set_id(1, 5'd2, 5'd2, 1, 5'd12, 1, 0, 0);
        tick();
        set_id(1, 5'd14, 5'd15, 1, 5'd0, 0, 0, 1);
        tick();
        mem_wait = 1'b1;
        flush_ex = 1'b1;
        set_id(1, 5'd14, 5'd0, 0, 5'd20, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            push_exp("hold_ex_rs",  F_EX_RS,     14);
            push_exp("hold_ex_rt",  F_EX_RT,     15);
            push_exp("hold_ex_mw",  F_EX_MEMWR,  1);
            push_exp("hold_mem_rd", F_MEM_RD,    12);
            push_exp("hold_mem_wr", F_MEM_REGWR, 1);
            push_exp("hold_wb_rd",  F_WB_RD,     11);
            push_exp("hold_wb_wr",  F_WB_REGWR,  1);
            push_exp("hold_cnt",    F_CNT,       3);
        end
        mem_wait = 1'b0;
        flush_ex = 1'b0;
        set_id(1, 5'd1, 5'd0, 0, 5'd16, 1, 1, 0);
        tick();
        push_exp("rel_ex_rs",  F_EX_RS,  1);
        push_exp("rel_mem_rd", F_MEM_RD, 0);
        push_exp("rel_wb_rd",  F_WB_RD,  12);
        set_id(1, 5'd16, 5'd0, 0, 5'd17, 1, 0, 0);
        flush_ex = 1'b1;
        push_exp("both_stall", F_STALL, 1);
        tick();
        push_exp("both_ex_rs",  F_EX_RS,  0);
        push_exp("both_mem_rd", F_MEM_RD, 16);
        push_exp("both_cnt",    F_CNT,    4);

        // Drive the counter to 0xFFFE, then check saturation
        set_id(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 32'hFFFE - 4; i++) begin
            tick();
        end
        push_exp("sat_fffe", F_CNT, 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            push_exp("sat_ffff", F_CNT, 32'hFFFF);
        end
        flush_ex = 1'b0;

        // Asynchronous reset between edges
        set_id(1, 5'd22, 5'd23, 1, 5'd21, 1, 0, 0);
        tick();
        idle();
        push_exp("pre_arst_ex_rs", F_EX_RS, 22);
        tick();
        RST = 1'b1;
        push_zero("arst");
        tick();
        RST = 1'b0;
        tick(); tick();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
